// File: rtl/alu_mdu.sv
// Execute-stage arithmetic: single-cycle ALU plus an iterative radix-2 multiply/divide
// unit with architectural HI/LO registers.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] z,
    output logic             ovf,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // ---------------- ALU ----------------
    logic [WIDTH:0]   add_ext, sub_ext;
    logic [SHW-1:0]   shamt;
    logic             lt_s, lt_u;

    assign add_ext = {x[WIDTH-1], x} + {y[WIDTH-1], y};
    assign sub_ext = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    assign shamt   = y[SHW-1:0];
    assign lt_s    = $signed(x) < $signed(y);
    assign lt_u    = x < y;

    always_comb begin
        z   = '0;
        ovf = 1'b0;
        case (alu_op)
            4'd0: begin
                z   = add_ext[WIDTH-1:0];
                ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
            end
            4'd1: begin
                z   = sub_ext[WIDTH-1:0];
                ovf = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
            end
            4'd2:    z = x + y;
            4'd3:    z = x - y;
            4'd4:    z = x & y;
            4'd5:    z = x | y;
            4'd6:    z = x ^ y;
            4'd7:    z = ~(x | y);
            4'd8:    z = x << shamt;
            4'd9:    z = x >> shamt;
            4'd10:   z = $unsigned($signed(x) >>> shamt);
            4'd11:   z = {{(WIDTH-1){1'b0}}, lt_s};
            4'd12:   z = {{(WIDTH-1){1'b0}}, lt_u};
            4'd13:   z = y << (WIDTH/2);
            default: z = '0;
        endcase
    end

    // ---------------- MDU ----------------
    // state | meaning
    // IDLE  | accepting requests; HI/LO stable
    // RUN   | one multiply/divide step per cycle, WIDTH cycles total
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] acc, mq, opnd;
    logic [SHW-1:0]   count;
    logic             is_div, neg_q, neg_r, div_zero;

    logic             accept, start_iter, last;
    logic             x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag;

    assign accept     = md_start && (state == IDLE);
    assign start_iter = accept && !md_op[2];
    assign last       = (state == RUN) && (count == SHW'(WIDTH-1));
    assign busy       = (state == RUN);

    // MULT and DIV (even opcodes) are the signed variants
    assign x_neg = !md_op[0] && x[WIDTH-1];
    assign y_neg = !md_op[0] && y[WIDTH-1];
    assign x_mag = x_neg ? -x : x;
    assign y_mag = y_neg ? -y : y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_iter) state_nxt = RUN;
            RUN:     if (last)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   acc_step, mq_step;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc, mq[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = !div_diff[WIDTH];

    always_comb begin
        if (is_div) begin
            acc_step = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            mq_step  = {mq[WIDTH-2:0], div_ok};
        end else begin
            acc_step = mul_sum[WIDTH:1];
            mq_step  = {mul_sum[0], mq[WIDTH-1:1]};
        end
    end

    // Divide by zero leaves the dividend magnitude in the remainder, so only LO needs forcing
    assign prod     = {acc_step, mq_step};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = div_zero ? '1 : (neg_q ? -mq_step : mq_step);
    assign rem_fix  = neg_r ? -acc_step : acc_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            mq       <= '0;
            opnd     <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (start_iter) begin
            acc      <= '0;
            mq       <= md_op[1] ? x_mag : y_mag;
            opnd     <= md_op[1] ? y_mag : x_mag;
            count    <= '0;
            is_div   <= md_op[1];
            neg_q    <= x_neg ^ y_neg;
            neg_r    <= x_neg;
            div_zero <= md_op[1] && (y == '0);
        end else if (accept) begin
            if (md_op == 3'd4) hi <= x;
            if (md_op == 3'd5) lo <= x;
        end else if (state == RUN) begin
            acc   <= acc_step;
            mq    <= mq_step;
            count <= count + 1'b1;
            if (last) begin
                if (is_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;
    logic        clk, reset_n;
    logic [31:0] x, y, z, hi, lo;
    logic [3:0]  alu_op;
    logic        ovf, md_start, busy;
    logic [2:0]  md_op;
    int          n_checks = 0;
    int          n_fails  = 0;
    int          n, n2;

    alu_mdu #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .alu_op(alu_op), .z(z), .ovf(ovf),
        .md_start(md_start), .md_op(md_op), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ez, input logic eovf);
        alu_op = op; x = a; y = b;
        #1;
        check({tag, ".z"}, 64'(z), 64'(ez));
        check({tag, ".ovf"}, 64'(ovf), 64'(eovf));
    endtask

    // Issues one request and returns the number of cycles busy stayed high
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        x = a; y = b; md_op = op; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic md_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int c;
        run_md(op, a, b, c);
        check({tag, ".cycles"}, 64'(c), 64'd32);
        check({tag, ".hi"}, 64'(hi), 64'(ehi));
        check({tag, ".lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        reset_n = 1'b0; x = '0; y = '0; alu_op = '0; md_start = 1'b0; md_op = '0;
        #3;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.hi", 64'(hi), 64'd0);
        check("rst.lo", 64'(lo), 64'd0);
        @(negedge clk); reset_n = 1'b1;

        alu_vec("add_ovf",  4'd0,  32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1);
        alu_vec("addu",     4'd2,  32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0);
        alu_vec("add_neg",  4'd0,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
        alu_vec("sub_ovf",  4'd1,  32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1);
        alu_vec("subu",     4'd3,  32'h5, 32'h7, 32'hFFFFFFFE, 1'b0);
        alu_vec("and",      4'd4,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0);
        alu_vec("or",       4'd5,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0);
        alu_vec("xor",      4'd6,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0);
        alu_vec("nor",      4'd7,  32'hF0000000, 32'h0000000F, 32'h0FFFFFF0, 1'b0);
        alu_vec("sll",      4'd8,  32'h00000003, 32'hFFFFFFE4, 32'h00000030, 1'b0);
        alu_vec("srl",      4'd9,  32'h80000000, 32'h4, 32'h08000000, 1'b0);
        alu_vec("sra",      4'd10, 32'h80000000, 32'h4, 32'hF8000000, 1'b0);
        alu_vec("slt",      4'd11, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
        alu_vec("sltu",     4'd12, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
        alu_vec("lui",      4'd13, 32'h0, 32'h0000ABCD, 32'hABCD0000, 1'b0);
        alu_vec("op14",     4'd14, 32'h1234, 32'h5678, 32'h0, 1'b0);

        md_vec("mult",      3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        md_vec("multu",     3'd1, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
        md_vec("div",       3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md_vec("divu_z",    3'd3, 32'h7, 32'h0, 32'h00000007, 32'hFFFFFFFF);
        md_vec("div_z",     3'd2, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        md_vec("div_mn",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        md_vec("divu_big",  3'd3, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF);

        // MTHI while busy must be dropped
        md_vec("mult_pre",  3'd1, 32'h5, 32'h9, 32'h0, 32'd45);
        @(negedge clk);
        x = 32'h2; y = 32'h3; md_op = 3'd1; md_start = 1'b1;
        @(negedge clk); md_start = 1'b0;
        repeat (4) @(negedge clk);
        x = 32'h12345678; md_op = 3'd4; md_start = 1'b1;
        @(negedge clk); md_start = 1'b0;
        check("drop.hi_during", 64'(hi), 64'd0);
        check("drop.lo_during", 64'(lo), 64'd45);
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        check("drop.hi", 64'(hi), 64'd0);
        check("drop.lo", 64'd6 ^ 64'(lo), 64'd0);
        run_md(3'd4, 32'h12345678, 32'h0, n);
        check("mthi.cycles", 64'(n), 64'd0);
        check("mthi.hi", 64'(hi), 64'h12345678);
        run_md(3'd5, 32'hCAFEF00D, 32'h0, n);
        check("mtlo.lo", 64'(lo), 64'hCAFEF00D);
        check("mtlo.hi", 64'(hi), 64'h12345678);
        run_md(3'd6, 32'h1, 32'h1, n);
        check("op6.busy", 64'(n), 64'd0);
        check("op6.hi", 64'(hi), 64'h12345678);

        // Reset in the middle of a multiply
        @(negedge clk);
        x = 32'h5; y = 32'h7; md_op = 3'd0; md_start = 1'b1;
        @(negedge clk); md_start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid.busy_before", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid.busy", 64'(busy), 64'd0);
        check("mid.hi", 64'(hi), 64'd0);
        check("mid.lo", 64'(lo), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        md_vec("mult_post", 3'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1);

        // Back-to-back MULTU then DIVU, second request held so it lands as busy drops
        @(negedge clk);
        x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; md_op = 3'd1; md_start = 1'b1;
        @(posedge clk); #1;
        x = 32'd100; y = 32'd7; md_op = 3'd3;
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        check("b2b.mul_hi", 64'(hi), 64'hFFFFFFFE);
        check("b2b.mul_lo", 64'(lo), 64'h00000001);
        @(posedge clk); #1;
        md_start = 1'b0;
        check("b2b.second_busy", 64'(busy), 64'd1);
        n2 = 1;
        while (busy && n2 < 100) begin @(posedge clk); #1; n2++; end
        check("b2b.total", 64'(n + n2 - 1), 64'd64);
        check("b2b.div_hi", 64'(hi), 64'd2);
        check("b2b.div_lo", 64'(lo), 64'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
